issue_select: RTL and testbench
===============================

Name: issue_select

Overview:
- Single-port issue queue and select scheduler for one execute pipe. Sits between rename/dispatch and the execute stage.
- Holds up to DEPTH micro-ops and wakes source operands from the execute bypass tag. Picks the oldest ready entry and drives a registered issue slot into execute.
- Honours branch kill and branch resolve via per-entry branch masks.

Parameters:
DEPTH, 8, number of queue entries (power of 2, >=2)
WIDTH_BRM, 4, branch-mask width (one bit per in-flight branch)
WIDTH_PRD, 7, physical register tag width
WIDTH_UOP, 7, micro-op code width

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  synchronous active-high reset
i_disp_valid  in  1  dispatch request
o_disp_ready  out  1  queue can accept; equals (count != DEPTH), from registered count only
i_disp_uop  in  WIDTH_UOP  micro-op code
i_disp_brmask  in  WIDTH_BRM  branches this uop depends on
i_disp_prs1, i_disp_prs2  in  WIDTH_PRD  source physical tags
i_disp_rdy1, i_disp_rdy2  in  1  source already available at dispatch
i_disp_pdst  in  WIDTH_PRD  destination physical tag
i_wake_valid  in  1  bypass wakeup valid (execute bypass valid bit)
i_wake_pdst  in  WIDTH_PRD  bypass destination tag
i_br_kill  in  1  mispredict kill valid
i_br_resolve  in  1  correct-prediction resolve valid
i_br_mask  in  WIDTH_BRM  one-hot branch bit for kill/resolve
i_ex_ready  in  1  execute accepts the issue slot this cycle
o_iss_valid  out  1  issue slot valid
o_iss_uop  out  WIDTH_UOP  issued uop
o_iss_brmask  out  WIDTH_BRM  issued branch mask (kept current under resolve)
o_iss_prs1, o_iss_prs2, o_iss_pdst  out  WIDTH_PRD  issued tags
o_count  out  log2(DEPTH)+1  occupied entries

Behaviour:
- Reset: all entry valids 0, count 0, o_iss_valid 0, all o_iss_* fields 0, o_disp_ready 1 on the first cycle after reset. Reset mid-operation discards all entries and the issue slot.
- Storage is a collapsing queue. Index 0 is oldest and valid entries are contiguous from index 0.
- Dispatch accepted when i_disp_valid && o_disp_ready. The entry is written at index (count minus entries removed this cycle), i.e. directly behind the surviving entries after compaction.
- Wakeup: each valid entry sets rdyN when i_wake_valid && prsN == i_wake_pdst.
  - The dispatching uop is also compared against the wake tag in its dispatch cycle.
  - Tag 0 is not special.
- Select:
  - Candidate = lowest index with valid && rdy1 && rdy2, using registered ready bits.
  - A wakeup in cycle N makes the entry selectable in cycle N+1, not N.
  - A dispatch in cycle N is selectable at the earliest in cycle N+1, so o_iss_valid goes high at the edge ending N+1.
- Issue fire = candidate exists && (!o_iss_valid || i_ex_ready) && candidate not killed this cycle.
  - On fire: the slot loads the candidate at the edge and the entry is removed.
  - If no fire and i_ex_ready: o_iss_valid clears.
  - If i_ex_ready is 0 with the slot valid: the slot holds all fields stable.
- Branch kill (i_br_kill):
  - Every entry with (brmask & i_br_mask) != 0 is invalidated.
  - The issue slot is cleared if its brmask hits, regardless of i_ex_ready.
  - A dispatching uop whose i_disp_brmask hits is dropped but still counts as accepted.
- Branch resolve (i_br_resolve): clears the i_br_mask bit in all entry brmasks, in o_iss_brmask and in the dispatching uop's mask.
- i_br_kill and i_br_resolve are never asserted together; the bench must not drive that case.
- Compaction: killed and issued entries are removed in the same edge. Survivors shift toward index 0 preserving relative age.
- count_next = count - removed + accepted_and_not_killed. o_count is registered.
- Full: with count == DEPTH, o_disp_ready is 0 even if an issue frees a slot this cycle. It rises the cycle after.
- Simultaneous wake, dispatch, issue and resolve in one cycle are all applied together at the same edge.

Test Plan:
- Reset, then dispatch uop=7'h13, prs1=5, prs2=6, rdy1=rdy2=1, pdst=9 -> o_iss_valid=1 two edges after dispatch, with o_iss_pdst=9, o_count returning to 0.
- Dispatch A (prs1=3 not ready) then B (ready), with i_ex_ready=1 -> B issues first. Wake tag 3 in cycle N -> A issues at the edge ending N+1, not N.
- Fill 8 entries with sources not ready -> o_disp_ready=0, o_count=8. Wake one tag -> issue, and o_disp_ready returns 1 one cycle later.
- Hold i_ex_ready=0 with slot valid and two ready entries -> slot fields stable, o_count unchanged. Release -> oldest ready issues next.
- Entries with brmask 4'b0010, 4'b0100, 4'b0000, plus the slot with 4'b0010; assert i_br_kill with i_br_mask=4'b0010 -> slot cleared and 1 entry removed, with order of the rest preserved.
- i_br_resolve with i_br_mask=4'b0100 while slot holds brmask 4'b0110 -> o_iss_brmask=4'b0010 next cycle. A later kill of bit 2 does not affect that uop.

Source files
------------

// File: rtl/issue_select.sv
// Collapsing issue queue with oldest-ready select for a single execute pipe.
// Tracks operand wakeup from the bypass tag and branch kill/resolve masks.
module issue_select #(
  parameter int DEPTH     = 8,
  parameter int WIDTH_BRM = 4,
  parameter int WIDTH_PRD = 7,
  parameter int WIDTH_UOP = 7
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_disp_valid,
  output logic                       o_disp_ready,
  input  logic [WIDTH_UOP-1:0]       i_disp_uop,
  input  logic [WIDTH_BRM-1:0]       i_disp_brmask,
  input  logic [WIDTH_PRD-1:0]       i_disp_prs1,
  input  logic [WIDTH_PRD-1:0]       i_disp_prs2,
  input  logic                       i_disp_rdy1,
  input  logic                       i_disp_rdy2,
  input  logic [WIDTH_PRD-1:0]       i_disp_pdst,
  input  logic                       i_wake_valid,
  input  logic [WIDTH_PRD-1:0]       i_wake_pdst,
  input  logic                       i_br_kill,
  input  logic                       i_br_resolve,
  input  logic [WIDTH_BRM-1:0]       i_br_mask,
  input  logic                       i_ex_ready,
  output logic                       o_iss_valid,
  output logic [WIDTH_UOP-1:0]       o_iss_uop,
  output logic [WIDTH_BRM-1:0]       o_iss_brmask,
  output logic [WIDTH_PRD-1:0]       o_iss_prs1,
  output logic [WIDTH_PRD-1:0]       o_iss_prs2,
  output logic [WIDTH_PRD-1:0]       o_iss_pdst,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic                 valid;
    logic [WIDTH_UOP-1:0] uop;
    logic [WIDTH_BRM-1:0] brm;
    logic [WIDTH_PRD-1:0] prs1;
    logic [WIDTH_PRD-1:0] prs2;
    logic [WIDTH_PRD-1:0] pdst;
    logic                 rdy1;
    logic                 rdy2;
  } ent_t;

  ent_t q     [DEPTH];
  ent_t q_nxt [DEPTH];
  ent_t upd   [DEPTH];
  ent_t din;

  logic [CW-1:0]        count;
  logic [CW-1:0]        count_nxt;
  logic [CW-1:0]        wp;
  logic [CW-1:0]        rank [DEPTH];
  logic [DEPTH-1:0]     cand_oh;
  logic [DEPTH-1:0]     killed;
  logic [DEPTH-1:0]     keep;
  logic                 cand_hit;
  logic                 cand_killed;
  logic                 fire;
  logic                 acc;
  logic                 din_kill;
  logic                 live;
  logic                 iss_kill;
  logic [WIDTH_BRM-1:0] clr;

  logic [WIDTH_UOP-1:0] sel_uop;
  logic [WIDTH_BRM-1:0] sel_brm;
  logic [WIDTH_PRD-1:0] sel_prs1;
  logic [WIDTH_PRD-1:0] sel_prs2;
  logic [WIDTH_PRD-1:0] sel_pdst;

  logic                 iss_valid;
  logic [WIDTH_UOP-1:0] iss_uop;
  logic [WIDTH_BRM-1:0] iss_brm;
  logic [WIDTH_PRD-1:0] iss_prs1;
  logic [WIDTH_PRD-1:0] iss_prs2;
  logic [WIDTH_PRD-1:0] iss_pdst;

  assign o_disp_ready = (count != CW'(DEPTH));
  assign clr          = i_br_resolve ? i_br_mask : '0;
  assign acc          = i_disp_valid && o_disp_ready;
  assign din_kill     = i_br_kill && |(i_disp_brmask & i_br_mask);
  assign live         = acc && !din_kill;
  assign iss_kill     = i_br_kill && |(iss_brm & i_br_mask);

  // Entry view after this cycle's wakeup and resolve.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      upd[i]      = q[i];
      upd[i].rdy1 = q[i].rdy1 |
                    (i_wake_valid && q[i].prs1 == i_wake_pdst);
      upd[i].rdy2 = q[i].rdy2 |
                    (i_wake_valid && q[i].prs2 == i_wake_pdst);
      upd[i].brm  = q[i].brm & ~clr;
      killed[i]   = q[i].valid && i_br_kill &&
                    |(q[i].brm & i_br_mask);
    end
  end

  always_comb begin
    din.valid = 1'b1;
    din.uop   = i_disp_uop;
    din.brm   = i_disp_brmask & ~clr;
    din.prs1  = i_disp_prs1;
    din.prs2  = i_disp_prs2;
    din.pdst  = i_disp_pdst;
    din.rdy1  = i_disp_rdy1 |
                (i_wake_valid && i_disp_prs1 == i_wake_pdst);
    din.rdy2  = i_disp_rdy2 |
                (i_wake_valid && i_disp_prs2 == i_wake_pdst);
  end

  // Oldest-ready pick uses registered ready bits only.
  always_comb begin
    cand_oh  = '0;
    cand_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!cand_hit && q[i].valid && q[i].rdy1 && q[i].rdy2) begin
        cand_oh[i] = 1'b1;
        cand_hit   = 1'b1;
      end
    end
  end

  assign cand_killed = |(cand_oh & killed);
  assign fire = cand_hit && (!iss_valid || i_ex_ready) &&
                !cand_killed;

  always_comb begin
    sel_uop  = '0;
    sel_brm  = '0;
    sel_prs1 = '0;
    sel_prs2 = '0;
    sel_pdst = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cand_oh[i]) begin
        sel_uop  = upd[i].uop;
        sel_brm  = upd[i].brm;
        sel_prs1 = upd[i].prs1;
        sel_prs2 = upd[i].prs2;
        sel_pdst = upd[i].pdst;
      end
    end
  end

  always_comb begin
    wp = '0;
    for (int i = 0; i < DEPTH; i++) begin
      keep[i] = q[i].valid && !killed[i] && !(fire && cand_oh[i]);
      rank[i] = wp;
      wp      = wp + CW'(keep[i]);
    end
  end

  // Survivors slide down by rank; the new uop lands right behind them.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      q_nxt[j] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (keep[i] && rank[i] == CW'(j)) q_nxt[j] = upd[i];
      end
      if (live && wp == CW'(j)) q_nxt[j] = din;
    end
    count_nxt = wp + CW'(live);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q[i] <= q_nxt[i];
      count <= count_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      iss_valid <= 1'b0;
      iss_uop   <= '0;
      iss_brm   <= '0;
      iss_prs1  <= '0;
      iss_prs2  <= '0;
      iss_pdst  <= '0;
    end else if (fire) begin
      iss_valid <= 1'b1;
      iss_uop   <= sel_uop;
      iss_brm   <= sel_brm;
      iss_prs1  <= sel_prs1;
      iss_prs2  <= sel_prs2;
      iss_pdst  <= sel_pdst;
    end else begin
      if (i_ex_ready || iss_kill) iss_valid <= 1'b0;
      iss_brm <= iss_brm & ~clr;
    end
  end

  assign o_iss_valid  = iss_valid;
  assign o_iss_uop    = iss_uop;
  assign o_iss_brmask = iss_brm;
  assign o_iss_prs1   = iss_prs1;
  assign o_iss_prs2   = iss_prs2;
  assign o_iss_pdst   = iss_pdst;
  assign o_count      = count;

endmodule

// File: tb/tb_issue_select.sv
// Directed bench for issue_select: select order, wakeup timing,
// full flow control, stall, branch kill and resolve.
module tb_issue_select;

  logic       clk = 1'b0;
  logic       rst;
  logic       disp_valid;
  logic       disp_ready;
  logic [6:0] disp_uop;
  logic [3:0] disp_brmask;
  logic [6:0] disp_prs1;
  logic [6:0] disp_prs2;
  logic       disp_rdy1;
  logic       disp_rdy2;
  logic [6:0] disp_pdst;
  logic       wake_valid;
  logic [6:0] wake_pdst;
  logic       br_kill;
  logic       br_resolve;
  logic [3:0] br_mask;
  logic       ex_ready;
  logic       iss_valid;
  logic [6:0] iss_uop;
  logic [3:0] iss_brmask;
  logic [6:0] iss_prs1;
  logic [6:0] iss_prs2;
  logic [6:0] iss_pdst;
  logic [3:0] count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  issue_select dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_disp_valid  (disp_valid),
    .o_disp_ready  (disp_ready),
    .i_disp_uop    (disp_uop),
    .i_disp_brmask (disp_brmask),
    .i_disp_prs1   (disp_prs1),
    .i_disp_prs2   (disp_prs2),
    .i_disp_rdy1   (disp_rdy1),
    .i_disp_rdy2   (disp_rdy2),
    .i_disp_pdst   (disp_pdst),
    .i_wake_valid  (wake_valid),
    .i_wake_pdst   (wake_pdst),
    .i_br_kill     (br_kill),
    .i_br_resolve  (br_resolve),
    .i_br_mask     (br_mask),
    .i_ex_ready    (ex_ready),
    .o_iss_valid   (iss_valid),
    .o_iss_uop     (iss_uop),
    .o_iss_brmask  (iss_brmask),
    .o_iss_prs1    (iss_prs1),
    .o_iss_prs2    (iss_prs2),
    .o_iss_pdst    (iss_pdst),
    .o_count       (count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic disp(input logic [6:0] uop, input logic [3:0] brm,
                      input logic [6:0] p1, input logic [6:0] p2,
                      input logic r1, input logic r2,
                      input logic [6:0] pd);
    disp_valid  = 1'b1;
    disp_uop    = uop;
    disp_brmask = brm;
    disp_prs1   = p1;
    disp_prs2   = p2;
    disp_rdy1   = r1;
    disp_rdy2   = r2;
    disp_pdst   = pd;
  endtask

  task automatic idle;
    disp_valid = 1'b0;
    wake_valid = 1'b0;
    br_kill    = 1'b0;
    br_resolve = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    disp_uop = '0; disp_brmask = '0; disp_prs1 = '0; disp_prs2 = '0;
    disp_rdy1 = 1'b0; disp_rdy2 = 1'b0; disp_pdst = '0;
    wake_pdst = '0; br_mask = '0; ex_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", 32'(iss_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(disp_ready), 1);
    chk("rst_pdst", 32'(iss_pdst), 0);
    chk("rst_uop", 32'(iss_uop), 0);
    rst = 1'b0;

    // single ready uop issues two edges after dispatch
    disp(7'h13, 4'b0000, 5, 6, 1, 1, 9);
    tick();
    idle();
    chk("t1_cnt1", 32'(count), 1);
    chk("t1_nov", 32'(iss_valid), 0);
    tick();
    chk("t1_val", 32'(iss_valid), 1);
    chk("t1_pdst", 32'(iss_pdst), 9);
    chk("t1_uop", 32'(iss_uop), 32'h13);
    chk("t1_prs", 32'({iss_prs1, iss_prs2}), 32'({7'd5, 7'd6}));
    chk("t1_cnt0", 32'(count), 0);
    tick();
    chk("t1_drain", 32'(iss_valid), 0);

    // younger ready uop bypasses older waiting one; wake latency
    disp(1, 4'b0000, 3, 4, 0, 1, 10);
    tick();
    disp(2, 4'b0000, 1, 2, 1, 1, 11);
    tick();
    idle();
    chk("t2_cnt2", 32'(count), 2);
    tick();
    chk("t2_b_val", 32'(iss_valid), 1);
    chk("t2_b_pdst", 32'(iss_pdst), 11);
    chk("t2_cnt1", 32'(count), 1);
    wake_valid = 1'b1; wake_pdst = 3;
    tick();
    idle();
    chk("t2_wake_n", 32'(iss_valid), 0);
    chk("t2_wake_cnt", 32'(count), 1);
    tick();
    chk("t2_a_val", 32'(iss_valid), 1);
    chk("t2_a_pdst", 32'(iss_pdst), 10);
    chk("t2_cnt0", 32'(count), 0);
    tick();

    // fill to full, wake one, ready returns the cycle after issue
    for (int i = 0; i < 8; i++) begin
      disp(7'(i), 4'b0000, 7'(20 + i), 7'(40 + i), 0, 1, 7'(60 + i));
      tick();
    end
    chk("t3_full_cnt", 32'(count), 8);
    chk("t3_full_rdy", 32'(disp_ready), 0);
    disp(7'h55, 4'b0000, 1, 1, 1, 1, 99);
    wake_valid = 1'b1; wake_pdst = 22;
    tick();
    wake_valid = 1'b0;
    chk("t3_wake_cnt", 32'(count), 8);
    chk("t3_wake_v", 32'(iss_valid), 0);
    tick();
    idle();
    chk("t3_iss_v", 32'(iss_valid), 1);
    chk("t3_iss_pdst", 32'(iss_pdst), 62);
    chk("t3_cnt7", 32'(count), 7);
    chk("t3_rdy_back", 32'(disp_ready), 1);

    // reset mid-operation drops queue and slot
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t3_rst_cnt", 32'(count), 0);
    chk("t3_rst_v", 32'(iss_valid), 0);
    chk("t3_rst_pdst", 32'(iss_pdst), 0);
    chk("t3_rst_rdy", 32'(disp_ready), 1);

    // stall holds slot; release issues oldest ready
    ex_ready = 1'b0;
    disp(3, 4'b0000, 1, 2, 1, 1, 30);
    tick();
    disp(4, 4'b0000, 1, 2, 1, 1, 31);
    tick();
    disp(5, 4'b0000, 1, 2, 1, 1, 32);
    tick();
    idle();
    chk("t4_hold_pdst", 32'(iss_pdst), 30);
    chk("t4_hold_cnt", 32'(count), 2);
    tick();
    chk("t4_hold2_v", 32'(iss_valid), 1);
    chk("t4_hold2_pdst", 32'(iss_pdst), 30);
    chk("t4_hold2_uop", 32'(iss_uop), 3);
    chk("t4_hold2_cnt", 32'(count), 2);
    ex_ready = 1'b1;
    tick();
    chk("t4_rel_pdst", 32'(iss_pdst), 31);
    chk("t4_rel_cnt", 32'(count), 1);
    tick();
    chk("t4_rel2_pdst", 32'(iss_pdst), 32);
    chk("t4_rel2_cnt", 32'(count), 0);
    tick();
    chk("t4_empty", 32'(iss_valid), 0);

    // branch kill clears slot and matching entries, keeps order
    ex_ready = 1'b0;
    disp(6, 4'b0010, 1, 2, 1, 1, 50);
    tick();
    disp(7, 4'b0010, 70, 2, 0, 1, 51);
    tick();
    disp(8, 4'b0100, 71, 2, 0, 1, 52);
    tick();
    disp(9, 4'b0000, 71, 2, 0, 1, 53);
    tick();
    chk("t5_slot_brm", 32'(iss_brmask), 32'b0010);
    chk("t5_slot_v", 32'(iss_valid), 1);
    chk("t5_cnt3", 32'(count), 3);
    disp(10, 4'b0010, 1, 2, 1, 1, 54);
    br_kill = 1'b1; br_mask = 4'b0010;
    tick();
    idle();
    chk("t5_kill_v", 32'(iss_valid), 0);
    chk("t5_kill_cnt", 32'(count), 2);
    ex_ready = 1'b1;
    wake_valid = 1'b1; wake_pdst = 71;
    tick();
    wake_valid = 1'b0;
    chk("t5_wake_v", 32'(iss_valid), 0);
    tick();
    chk("t5_first", 32'(iss_pdst), 52);
    chk("t5_first_cnt", 32'(count), 1);
    tick();
    chk("t5_second", 32'(iss_pdst), 53);
    chk("t5_second_v", 32'(iss_valid), 1);
    chk("t5_cnt0", 32'(count), 0);
    tick();

    // resolve clears a mask bit in slot and queue
    ex_ready = 1'b0;
    disp(11, 4'b0110, 1, 2, 1, 1, 80);
    tick();
    disp(12, 4'b0100, 90, 2, 0, 1, 81);
    tick();
    idle();
    chk("t6_slot_brm", 32'(iss_brmask), 32'b0110);
    chk("t6_slot_pdst", 32'(iss_pdst), 80);
    br_resolve = 1'b1; br_mask = 4'b0100;
    tick();
    idle();
    chk("t6_res_brm", 32'(iss_brmask), 32'b0010);
    chk("t6_res_v", 32'(iss_valid), 1);
    br_kill = 1'b1; br_mask = 4'b0100;
    tick();
    idle();
    chk("t6_kill_v", 32'(iss_valid), 1);
    chk("t6_kill_brm", 32'(iss_brmask), 32'b0010);
    chk("t6_kill_cnt", 32'(count), 1);
    ex_ready = 1'b1;
    wake_valid = 1'b1; wake_pdst = 90;
    tick();
    wake_valid = 1'b0;
    chk("t6_drain_v", 32'(iss_valid), 0);
    tick();
    chk("t6_q_pdst", 32'(iss_pdst), 81);
    chk("t6_q_brm", 32'(iss_brmask), 0);
    chk("t6_cnt0", 32'(count), 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
